// File: rtl/count16_timer_ctrl.sv
// count16_timer_ctrl: run/pause/done controller for an external up-counter.
// It sequences one-shot or periodic intervals of PeriodReg+1 clocks. It also
// pulses Done per completed interval and counts completed intervals, saturating.
module count16_timer_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned PCNT_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Abort,
  input  logic              Mode,
  input  logic [WIDTH-1:0]  Period,
  input  logic [WIDTH-1:0]  CountQ,
  output logic              CntEnable,
  output logic              CntClear,
  output logic              Done,
  output logic              Err,
  output logic              Busy,
  output logic [1:0]        State,
  output logic [PCNT_W-1:0] PeriodCnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

  state_t              r_state;
  logic [WIDTH-1:0]    r_period;
  logic                r_mode;
  logic                r_done;
  logic                r_err;
  logic [PCNT_W-1:0]   r_pcnt;

  state_t              w_next_state;
  logic                w_terminal;
  logic                w_period_zero;
  logic                w_latch;
  logic                w_done_set;
  logic                w_err_set;
  logic                w_pcnt_clr;

  assign w_terminal    = (r_state == S_RUN) && (CountQ == r_period);
  assign w_period_zero = (Period == '0);

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and event decode; Abort overrides everything else
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_done_set   = 1'b0;
    w_err_set    = 1'b0;
    w_pcnt_clr   = 1'b0;
    if (Abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (w_period_zero) begin
              w_err_set = 1'b1;
            end else begin
              w_next_state = S_RUN;
              w_latch      = 1'b1;
              w_pcnt_clr   = 1'b1;
            end
          end
        end
        S_RUN: begin
          // Terminal wins over a simultaneous Stop
          if (w_terminal) begin
            w_done_set = 1'b1;
            if (!r_mode) begin
              w_next_state = S_DONE;
            end else if (Stop) begin
              w_next_state = S_PAUSE;
            end else begin
              w_next_state = S_RUN;
            end
          end else if (Stop) begin
            w_next_state = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (Start) begin
            w_next_state = S_RUN;
          end
        end
        S_DONE: begin
          if (Start) begin
            if (w_period_zero) begin
              w_err_set = 1'b1;
            end else begin
              w_next_state = S_RUN;
              w_latch      = 1'b1;
            end
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Counter control and status decode
  always_comb begin
    CntEnable = (r_state == S_RUN) && !w_terminal && !Stop && !Abort;
    CntClear  = (r_state == S_IDLE) || Abort || (w_terminal && r_mode) ||
                ((r_state == S_DONE) && Start);
    Busy      = (r_state == S_RUN) || (r_state == S_PAUSE);
  end

  // Period/mode latch, one-cycle pulses and saturating period count
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_period <= '0;
      r_mode   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_pcnt   <= '0;
    end else begin
      r_done <= w_done_set;
      r_err  <= w_err_set;
      if (w_latch) begin
        r_period <= Period;
        r_mode   <= Mode;
      end
      if (w_pcnt_clr) begin
        r_pcnt <= '0;
      end else if (w_done_set && (r_pcnt != PCNT_MAX)) begin
        r_pcnt <= r_pcnt + PCNT_W'(1);
      end
    end
  end

  assign State     = r_state;
  assign Done      = r_done;
  assign Err       = r_err;
  assign PeriodCnt = r_pcnt;

endmodule

// File: tb/tb_count16_timer_ctrl.sv
// Bench for count16_timer_ctrl: external counter, spec-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_count16_timer_ctrl;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned PCNT_W = 2;
  localparam int PMAX = (1 << PCNT_W) - 1;
  localparam int S_I = 0, S_R = 1, S_P = 2, S_D = 3;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              Start = 1'b0;
  logic              Stop  = 1'b0;
  logic              Abort = 1'b0;
  logic              Mode  = 1'b0;
  logic [WIDTH-1:0]  Period = '0;
  logic [WIDTH-1:0]  cnt = '0;
  logic              CntEnable, CntClear, Done, Err, Busy;
  logic [1:0]        State;
  logic [PCNT_W-1:0] PeriodCnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  count16_timer_ctrl #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop), .Abort(Abort),
    .Mode(Mode), .Period(Period), .CountQ(cnt), .CntEnable(CntEnable),
    .CntClear(CntClear), .Done(Done), .Err(Err), .Busy(Busy), .State(State),
    .PeriodCnt(PeriodCnt)
  );

  always #5 Clock = ~Clock;

  // Controlled counter: clear beats enable
  always @(posedge Clock) begin
    if (CntClear) cnt <= '0;
    else if (CntEnable) cnt <= cnt + 16'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: timer state expressed as accept/terminal rules on plain ints
  int m_state = S_I, m_per = 0, m_mode = 0, m_done = 0, m_err = 0, m_pcnt = 0;
  bit m_hit;
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_state = S_I; m_per = 0; m_mode = 0; m_done = 0; m_err = 0; m_pcnt = 0;
    end else begin
      m_hit  = (m_state == S_R) && (int'(cnt) == m_per);
      m_done = 0;
      m_err  = 0;
      if (Abort) begin
        m_state = S_I;
      end else if ((m_state == S_I || m_state == S_D) && Start) begin
        if (Period == 0) m_err = 1;
        else begin
          if (m_state == S_I) m_pcnt = 0;
          m_per = int'(Period); m_mode = int'(Mode); m_state = S_R;
        end
      end else if (m_state == S_P && Start) begin
        m_state = S_R;
      end else if (m_hit) begin
        m_done = 1;
        m_pcnt = (m_pcnt == PMAX) ? PMAX : m_pcnt + 1;
        m_state = (m_mode == 0) ? S_D : (Stop ? S_P : S_R);
      end else if (m_state == S_R && Stop) begin
        m_state = S_P;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge Clock) begin : cmp
    bit h;
    if (armed && !Reset) begin
      h = (m_state == S_R) && (int'(cnt) == m_per);
      check("State", 32'(State), 32'(m_state));
      check("Busy", 32'(Busy), 32'(m_state == S_R || m_state == S_P));
      check("Done", 32'(Done), 32'(m_done));
      check("Err", 32'(Err), 32'(m_err));
      check("PeriodCnt", 32'(PeriodCnt), 32'(m_pcnt));
      check("CntEnable", 32'(CntEnable), 32'(m_state == S_R && !h && !Stop && !Abort));
      check("CntClear", 32'(CntClear),
            32'(m_state == S_I || Abort || (h && m_mode == 1) || (m_state == S_D && Start)));
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_run(input int per, input bit md);
    Period = WIDTH'(per); Mode = md; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic do_abort();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
  endtask

  initial begin
    int exp_seq [8];
    int k;
    int dcount;
    bit ok;
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};

    Reset = 1'b1;
    ticks(2);
    check("rst_State", 32'(State), 32'd0);
    check("rst_Busy", 32'(Busy), 32'd0);
    check("rst_CntEnable", 32'(CntEnable), 32'd0);
    check("rst_CntClear", 32'(CntClear), 32'd1);
    check("rst_PeriodCnt", 32'(PeriodCnt), 32'd0);
    Reset = 1'b0;
    armed = 1'b1;
    tick();

    // Periodic, period 3
    start_run(3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("per_CountQ", 32'(cnt), 32'(exp_seq[i]));
      check("per_Done", 32'(Done), 32'(i == 4));
      tick();
    end
    check("per_PeriodCnt", 32'(PeriodCnt), 32'd2);
    check("per_Done_last", 32'(Done), 32'd1);
    do_abort();
    check("abort_keeps_pcnt", 32'(PeriodCnt), 32'd2);
    check("abort_State", 32'(State), 32'd0);

    // One-shot, period 5
    start_run(5, 1'b0);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      dcount += int'(Done);
    end
    check("os_CountQ", 32'(cnt), 32'd5);
    check("os_State", 32'(State), 32'd3);
    check("os_Busy", 32'(Busy), 32'd0);
    check("os_done_count", 32'(dcount), 32'd1);
    check("os_PeriodCnt", 32'(PeriodCnt), 32'd1);
    start_run(0, 1'b0);
    check("done_zero_Err", 32'(Err), 32'd1);
    check("done_zero_State", 32'(State), 32'd3);
    start_run(5, 1'b0);
    check("restart_State", 32'(State), 32'd1);
    check("restart_CountQ", 32'(cnt), 32'd0);
    tick();
    check("restart_CountQ1", 32'(cnt), 32'd1);
    do_abort();

    // Pause and resume, period 10
    start_run(10, 1'b0);
    ticks(4);
    check("pause_pre", 32'(cnt), 32'd4);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    check("pause_State", 32'(State), 32'd2);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ok &= (cnt == 16'd4) && (State == 2'b10);
      tick();
    end
    check("pause_hold", 32'(ok), 32'd1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    check("resume_CountQ", 32'(cnt), 32'd5);
    k = 0;
    while (k < 20) begin
      tick();
      if (Done) break;
      k++;
    end
    check("resume_wait", 32'(k), 32'd5);
    check("resume_CountQ_done", 32'(cnt), 32'd10);
    do_abort();

    // Zero period from IDLE
    start_run(0, 1'b1);
    check("zero_Err", 32'(Err), 32'd1);
    check("zero_State", 32'(State), 32'd0);
    check("zero_CntEnable", 32'(CntEnable), 32'd0);
    tick();
    check("zero_Err_once", 32'(Err), 32'd0);

    // Abort mid-run, period 20
    start_run(20, 1'b1);
    ticks(7);
    check("ab_pre", 32'(cnt), 32'd7);
    do_abort();
    check("ab_State", 32'(State), 32'd0);
    check("ab_CountQ", 32'(cnt), 32'd0);
    check("ab_PeriodCnt", 32'(PeriodCnt), 32'd0);

    // Periodic terminal together with Stop
    start_run(2, 1'b1);
    ticks(2);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    check("ts_State", 32'(State), 32'd2);
    check("ts_CountQ", 32'(cnt), 32'd0);
    check("ts_Done", 32'(Done), 32'd1);
    do_abort();

    // Saturation then asynchronous reset
    start_run(1, 1'b1);
    ticks(10);
    check("sat_PeriodCnt", 32'(PeriodCnt), 32'd3);
    tick();
    #1 Reset = 1'b1;
    #1;
    check("arst_State", 32'(State), 32'd0);
    check("arst_Done", 32'(Done), 32'd0);
    check("arst_Err", 32'(Err), 32'd0);
    check("arst_PeriodCnt", 32'(PeriodCnt), 32'd0);
    check("arst_Busy", 32'(Busy), 32'd0);
    check("arst_CntEnable", 32'(CntEnable), 32'd0);
    check("arst_CntClear", 32'(CntClear), 32'd1);
    ticks(2);
    Reset = 1'b0;
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
